axi4_mem_ctrl: RTL and testbench
================================

Name: axi4_mem_ctrl

Overview:
- AXI4 slave controller that sequences the single-port word memory (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata, 1-cycle registered read).
- Accepts AXI4 read and write bursts, arbitrates between them, generates per-beat memory accesses, and returns B/R responses.
- One transaction in flight at a time; sits between the AXI interconnect and the memory instance.

Parameters:
- DATA_WIDTH, 32, AXI and memory data width; fixed 4-byte beats.
- ADDR_WIDTH, 16, AXI byte-address width.
- MEM_AW, 10, memory word-address width.
- DEPTH, 1024, memory words; valid byte range is 0 to DEPTH*4-1.
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address channel
- awvalid  in  1 ; awready  out  1
- wdata  in  DATA_WIDTH ; wstrb  in  DATA_WIDTH/8 (ignored) ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
- bid  out  ID_WIDTH ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
- arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address channel
- arvalid  in  1 ; arready  out  1
- rid  out  ID_WIDTH ; rdata  out  DATA_WIDTH ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
- mem_en  out  1 ; mem_we  out  1 ; mem_addr  out  MEM_AW ; mem_wdata  out  DATA_WIDTH ; mem_rdata  in  DATA_WIDTH

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all ready/valid outputs 0; bresp=rresp=0; rlast=0; bid=rid=0; priority pointer = write. mem_en=0.
- States: IDLE, W_DATA, W_RESP, R_ISSUE, R_DATA.
- IDLE: awready/arready asserted combinationally only toward the granted side. If both awvalid and arvalid are high, grant the side named by the priority pointer; the pointer then toggles to the other side. A single requester is granted regardless of the pointer. The handshake latches ID, address, len, burst, and sets beat_cnt=0 and err=0. Next state is W_DATA or R_ISSUE.
- Address per beat: byte addr; mem_addr = addr[MEM_AW+1:2]. INCR (and 2'b10/2'b11, treated as INCR) adds 4 after each beat. FIXED holds the address. The counter wraps mod 2^ADDR_WIDTH.
- Out of range: addr >= DEPTH*4 makes that beat out of range. Writes suppress mem_en. Reads force rdata=0 and rresp=SLVERR (2'b10) for that beat.
- W_DATA: wready=1. On wvalid&wready: mem_en=mem_we=1 (unless out of range), mem_addr and mem_wdata driven combinationally in the same cycle; advance addr; beat_cnt++.
  - Set err if the beat is out of range.
  - Set err if wlast does not match (beat_cnt==len).
  - After beat len+1 (counter-terminated; wlast is not used for termination), go to W_RESP.
- W_RESP: bvalid=1, bid=latched ID, bresp = err ? SLVERR : OKAY. Hold until bready, then go to IDLE. Zero wait states between W_DATA and W_RESP.
- R_ISSUE: mem_en=1, mem_we=0 for one cycle, then R_DATA.
- R_DATA: rvalid=1, rdata=mem_rdata (stable because mem_en=0), rid=latched ID, rlast=(beat_cnt==len). On rready: advance addr and beat_cnt. If it was the last beat go to IDLE, else R_ISSUE. Throughput is 1 beat per 2 cycles plus rready stall.
- Outputs stay stable while valid and not ready (AXI rule).
- Reset mid-burst: abort at that edge with no response and no further mem_en. A partially written burst stays in memory.
- arready and awready are never both high in the same cycle.

Decomposition:
- Package axi4_pkg holds:
  - resp constants OKAY=2'b00 and SLVERR=2'b10;
  - burst constants FIXED=2'b00 and INCR=2'b01;
  - the state enum typedef.
- Optional sub-module axi4_rr_arb: 2-requester round-robin (pointer flop + grant logic) used in IDLE.
- Memory is instantiated by the parent, not inside this block.

Test Plan:
- Single write, then read: AW addr 0x010 len 0, W 0xDEADBEEF -> mem_addr=4, mem_we=1; bresp OKAY. AR 0x010 -> rdata 0xDEADBEEF, rlast=1, rresp OKAY.
- INCR write burst: addr 0x100 len 3, data 1..4 -> mem_addr 64..67 written; then read INCR len 3 -> data 1,2,3,4, rlast only on beat 4.
- FIXED read: len 2 at 0x010 -> three beats all 0xDEADBEEF, mem_addr=4 each beat.
- Simultaneous awvalid and arvalid after reset -> write granted first; the next simultaneous pair -> read granted first.
- Out of range: write at 0x1000 (DEPTH=1024) -> no mem_en, bresp SLVERR. Read at 0x0FFC len 1 -> beat 0 OKAY, beat 1 rdata 0 with SLVERR.
- Backpressure and reset: rready low for 5 cycles holds rvalid/rdata stable. rst_n low mid-burst at beat 2 -> next cycle all valids 0, state IDLE, no bvalid.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared constants and FSM state encoding for the AXI4 slave memory controller.
package axi4_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_DATA  = 3'd1,
    W_RESP  = 3'd2,
    R_ISSUE = 3'd3,
    R_DATA  = 3'd4
  } state_t;

endpackage

// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 write/read channel bundle between interconnect (master) and the controller (slave).
// Valid/ready: a transfer happens on a rising clk edge where both are high; the source holds its payload steady from valid until that edge.
interface axi4_mem_ctrl_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi4_rr_arb.sv
// Two-requester round-robin arbiter (write vs read); the pointer only moves when both contend.
module axi4_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);
  logic prio_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_w <= 1'b1;
    end else if (en && req_w && req_r) begin
      prio_w <= ~prio_w;
    end
  end

  always_comb begin
    gnt_w = en && req_w && (!req_r || prio_w);
    gnt_r = en && req_r && (!req_w || !prio_w);
  end
endmodule

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave that turns one burst at a time into per-beat accesses of a single-port word memory
// with a 1-cycle registered read.
module axi4_mem_ctrl
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_AW     = 10,
  parameter int DEPTH      = 1024,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_mem_ctrl_if.slave        axi,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output state_t                dbg_state
);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH*4);

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   id, id_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, addr_adv;
  logic [7:0]            len, len_nxt, beat_cnt, cnt_nxt;
  logic [1:0]            burst, burst_nxt;
  logic                  err, err_nxt;
  logic                  oor, last_beat, gnt_w, gnt_r;
  logic                  unused_wstrb;

  assign unused_wstrb = ^axi.wstrb;

  axi4_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req_w (axi.awvalid),
    .req_r (axi.arvalid),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  // FIXED holds the address; INCR and the reserved encodings step by one word.
  assign addr_adv  = (burst == FIXED) ? addr : addr + ADDR_WIDTH'(4);
  assign oor       = {1'b0, addr} >= LIMIT;
  assign last_beat = (beat_cnt == len);
  assign mem_addr  = addr[MEM_AW+1:2];
  assign mem_wdata = axi.wdata;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      id       <= '0;
      addr     <= '0;
      len      <= '0;
      burst    <= FIXED;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      id       <= id_nxt;
      addr     <= addr_nxt;
      len      <= len_nxt;
      burst    <= burst_nxt;
      beat_cnt <= cnt_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    id_nxt      = id;
    addr_nxt    = addr;
    len_nxt     = len;
    burst_nxt   = burst;
    cnt_nxt     = beat_cnt;
    err_nxt     = err;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = OKAY;
    axi.rvalid  = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = OKAY;
    axi.rlast   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        axi.awready = gnt_w;
        axi.arready = gnt_r;
        if (gnt_w) begin
          id_nxt    = axi.awid;
          addr_nxt  = axi.awaddr;
          len_nxt   = axi.awlen;
          burst_nxt = axi.awburst;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = W_DATA;
        end else if (gnt_r) begin
          id_nxt    = axi.arid;
          addr_nxt  = axi.araddr;
          len_nxt   = axi.arlen;
          burst_nxt = axi.arburst;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = R_ISSUE;
        end
      end
      W_DATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          mem_en   = !oor;
          mem_we   = !oor;
          addr_nxt = addr_adv;
          cnt_nxt  = beat_cnt + 8'd1;
          // wlast is only checked; the beat counter alone ends the burst.
          if (oor || (axi.wlast != last_beat)) err_nxt = 1'b1;
          if (last_beat) state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        axi.bid    = id;
        axi.bresp  = err ? SLVERR : OKAY;
        if (axi.bready) state_nxt = IDLE;
      end
      R_ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = R_DATA;
      end
      R_DATA: begin
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = oor ? '0 : mem_rdata;
        axi.rresp  = oor ? SLVERR : OKAY;
        axi.rlast  = last_beat;
        if (axi.rready) begin
          addr_nxt  = addr_adv;
          cnt_nxt   = beat_cnt + 8'd1;
          state_nxt = last_beat ? IDLE : R_ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A reset edge must not commit a memory access from the aborted burst.
    if (!rst_n) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// Directed bench for axi4_mem_ctrl: word memory model, reference memory, and B/R expectation queues.
module tb_axi4_mem_ctrl;
  import axi4_pkg::*;

  localparam int DW = 32, AW = 16, MAW = 10, DEPTH = 1024, IDW = 4;
  localparam int RW = IDW + DW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_mem_ctrl_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  logic           mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  state_t         dbg_state;

  axi4_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .DEPTH(DEPTH), .ID_WIDTH(IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi       (axi),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  logic [DW-1:0] mem     [0:DEPTH-1] = '{default: '0};
  logic [DW-1:0] ref_mem [0:DEPTH-1] = '{default: '0};
  int             mem_en_cnt = 0;
  logic [MAW-1:0] last_rd_addr = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else begin
        mem_rdata    <= mem[mem_addr];
        last_rd_addr <= mem_addr;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0]    exp_q[$];
  logic [IDW+1:0]   b_exp_q[$];
  logic [DW-1:0]    wd_q[$];

  logic [IDW-1:0] cur_w_id, cur_r_id;
  logic [AW-1:0]  cur_w_addr, cur_r_addr;
  logic [7:0]     cur_w_len, cur_r_len;
  logic [1:0]     cur_w_burst, cur_r_burst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [AW-1:0] a);
    return int'(a) >= DEPTH * 4;
  endfunction

  function automatic logic [AW-1:0] next_a(input logic [AW-1:0] a, input logic [1:0] bt);
    return (bt == FIXED) ? a : a + 16'd4;
  endfunction

  task automatic aw_start(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [1:0] bt);
    cur_w_id = id; cur_w_addr = a; cur_w_len = len; cur_w_burst = bt;
    axi.awid = id; axi.awaddr = a; axi.awlen = len; axi.awburst = bt; axi.awvalid = 1'b1;
  endtask

  task automatic ar_start(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [1:0] bt);
    cur_r_id = id; cur_r_addr = a; cur_r_len = len; cur_r_burst = bt;
    axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arburst = bt; axi.arvalid = 1'b1;
  endtask

  task automatic aw_finish();
    int t = 0;
    #1;
    while (!axi.awready && t < 20) begin @(negedge clk); #1; t++; end
    chk("aw_handshake", 64'(axi.awready), 64'(1));
    @(posedge clk); @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_finish();
    int t = 0;
    logic [AW-1:0] a = cur_r_addr;
    #1;
    while (!axi.arready && t < 20) begin @(negedge clk); #1; t++; end
    chk("ar_handshake", 64'(axi.arready), 64'(1));
    @(posedge clk); @(negedge clk);
    axi.arvalid = 1'b0;
    for (int b = 0; b <= int'(cur_r_len); b++) begin
      if (is_oor(a)) exp_q.push_back({cur_r_id, 32'h0, SLVERR, 1'(b == int'(cur_r_len))});
      else exp_q.push_back({cur_r_id, ref_mem[a[MAW+1:2]], OKAY, 1'(b == int'(cur_r_len))});
      a = next_a(a, cur_r_burst);
    end
  endtask

  task automatic w_phase(input int bad_beat, input int abort_at);
    logic [AW-1:0] a = cur_w_addr;
    logic e = 1'b0;
    logic wl, oo;
    logic [DW-1:0] d;
    for (int b = 0; b <= int'(cur_w_len); b++) begin
      d  = wd_q.pop_front();
      oo = is_oor(a);
      wl = (b == int'(cur_w_len)) ^ (b == bad_beat);
      axi.wvalid = 1'b1; axi.wdata = d; axi.wlast = wl;
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", 64'(mem_en), 64'(0));
        @(posedge clk); @(negedge clk);
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        #1;
        chk("abort_state", 64'(dbg_state), 64'(IDLE));
        chk("abort_valids", 64'({axi.bvalid, axi.rvalid, axi.wready, mem_en}), 64'(0));
        rst_n = 1'b1;
        wd_q.delete();
        return;
      end
      #1;
      chk("w_ready", 64'(axi.wready), 64'(1));
      chk("w_mem_en_we", 64'({mem_en, mem_we}), 64'({!oo, !oo}));
      if (!oo) begin
        chk("w_mem_addr", 64'(mem_addr), 64'(a[MAW+1:2]));
        chk("w_mem_wdata", 64'(mem_wdata), 64'(d));
        ref_mem[a[MAW+1:2]] = d;
      end
      if (oo || (wl != (b == int'(cur_w_len)))) e = 1'b1;
      @(posedge clk); @(negedge clk);
      a = next_a(a, cur_w_burst);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    b_exp_q.push_back({cur_w_id, e ? SLVERR : OKAY});
  endtask

  task automatic b_phase();
    int t = 0;
    logic [IDW+1:0] exp;
    #1;
    while (!axi.bvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("b_valid", 64'(axi.bvalid), 64'(1));
    exp = b_exp_q.pop_front();
    chk("b_resp", 64'({axi.bid, axi.bresp}), 64'(exp));
    @(negedge clk); #1;
    chk("b_hold", 64'({axi.bvalid, axi.bid, axi.bresp}), 64'({1'b1, exp}));
    axi.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic r_phase(input int stall_beat, input int stall_cyc,
                         input logic chk_fixed, input logic [MAW-1:0] fix_addr);
    int t;
    logic [RW-1:0] exp;
    for (int b = 0; b <= int'(cur_r_len); b++) begin
      t = 0;
      #1;
      while (!axi.rvalid && t < 20) begin @(negedge clk); #1; t++; end
      chk("r_valid", 64'(axi.rvalid), 64'(1));
      exp = exp_q.pop_front();
      chk("r_beat", 64'({axi.rid, axi.rdata, axi.rresp, axi.rlast}), 64'(exp));
      if (chk_fixed) chk("r_fixed_addr", 64'(last_rd_addr), 64'(fix_addr));
      if (b == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk); #1;
          chk("r_hold", 64'({axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast}),
              64'({1'b1, exp}));
        end
      end
      axi.rready = 1'b1;
      @(posedge clk); @(negedge clk);
      axi.rready = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (axi.awready || axi.arready) chk("one_ready", 64'(axi.awready && axi.arready), 64'(0));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '1; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_outputs", 64'({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid,
                             axi.rlast, axi.bresp, axi.rresp, axi.bid, axi.rid, mem_en}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: write wins, read waits behind it.
    aw_start(4'd1, 16'h0020, 8'd0, INCR);
    ar_start(4'd2, 16'h0020, 8'd0, INCR);
    #1;
    chk("arb1_grant", 64'({axi.awready, axi.arready}), 64'(2'b10));
    wd_q.push_back(32'h1111_1111);
    aw_finish(); w_phase(-1, -1); b_phase();
    ar_finish(); r_phase(-1, 0, 1'b0, '0);

    // Next contention: read wins and sees the old contents.
    aw_start(4'd3, 16'h0030, 8'd0, INCR);
    ar_start(4'd4, 16'h0030, 8'd0, INCR);
    #1;
    chk("arb2_grant", 64'({axi.awready, axi.arready}), 64'(2'b01));
    ar_finish(); r_phase(-1, 0, 1'b0, '0);
    wd_q.push_back(32'h2222_2222);
    aw_finish(); w_phase(-1, -1); b_phase();

    // Single write and read-back.
    aw_start(4'd5, 16'h0010, 8'd0, INCR);
    wd_q.push_back(32'hDEAD_BEEF);
    aw_finish(); w_phase(-1, -1); b_phase();
    ar_start(4'd6, 16'h0010, 8'd0, INCR);
    ar_finish(); r_phase(-1, 0, 1'b0, '0);

    // INCR burst of four, read back with a 5-cycle rready stall on beat 1.
    aw_start(4'd7, 16'h0100, 8'd3, INCR);
    for (int i = 1; i <= 4; i++) wd_q.push_back(32'(i));
    aw_finish(); w_phase(-1, -1); b_phase();
    ar_start(4'd8, 16'h0100, 8'd3, INCR);
    ar_finish(); r_phase(1, 5, 1'b0, '0);

    // FIXED read of three beats from word 4.
    ar_start(4'd9, 16'h0010, 8'd2, FIXED);
    ar_finish(); r_phase(-1, 0, 1'b1, 10'd4);

    // wlast asserted early on a two-beat write.
    aw_start(4'd10, 16'h0040, 8'd1, INCR);
    wd_q.push_back(32'h0BAD_0001); wd_q.push_back(32'h0BAD_0002);
    aw_finish(); w_phase(0, -1); b_phase();

    // Top word of memory, then writes/reads across the end of the range.
    aw_start(4'd11, 16'h0FFC, 8'd0, INCR);
    wd_q.push_back(32'hCAFE_0001);
    aw_finish(); w_phase(-1, -1); b_phase();
    begin
      int en0;
      en0 = mem_en_cnt;
      aw_start(4'd12, 16'h1000, 8'd0, INCR);
      wd_q.push_back(32'h5555_AAAA);
      aw_finish(); w_phase(-1, -1); b_phase();
      chk("oor_no_mem_en", 64'(mem_en_cnt), 64'(en0));
    end
    ar_start(4'd13, 16'h0FFC, 8'd1, INCR);
    ar_finish(); r_phase(-1, 0, 1'b0, '0);

    // Reset during beat 2 of a four-beat write; earlier beats remain in memory.
    aw_start(4'd14, 16'h0200, 8'd3, INCR);
    for (int i = 0; i < 4; i++) wd_q.push_back(32'hA0 + 32'(i));
    aw_finish(); w_phase(-1, 2);
    @(negedge clk); #1;
    chk("post_abort_bvalid", 64'(axi.bvalid), 64'(0));
    @(negedge clk);
    ar_start(4'd15, 16'h0200, 8'd2, INCR);
    ar_finish(); r_phase(-1, 0, 1'b0, '0);

    chk("queues_drained", 64'(exp_q.size() + b_exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
